// File: rtl/nrst_sequencer.sv
// nrst_sequencer: ordered reset-release controller.
// All downstream active-low resets assert together, asynchronously, with NRST_I.
// After the master reset is released, the domains come out of reset one at a
// time in index order. Each release follows a fixed delay, and the next domain
// waits until the current one reports ready. A ready timeout re-asserts every
// domain and raises a sticky fault that only SRST_I or NRST_I can clear.

module nrst_sequencer #(
  parameter int N_DOM   = 3,
  parameter int STAGES  = 3,
  parameter int DLY_CYC = 4,
  parameter int TMO_CYC = 8,
  localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
  input  logic             CLK_I,
  input  logic             NRST_I,
  input  logic             SRST_I,
  input  logic [N_DOM-1:0] RDY_I,
  output logic [N_DOM-1:0] NRST_O,
  output logic             DONE_O,
  output logic             FAULT_O,
  output logic [IDX_W-1:0] FAULT_IDX_O
);

  // The counter covers both the release delay and the ready timeout.
  // It has at least one bit and saturates instead of wrapping.
  localparam int CNT_MAX_A = (DLY_CYC > TMO_CYC) ? DLY_CYC : TMO_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
  localparam int CNT_W     = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);
  localparam bit               TMO_EN   = (TMO_CYC != 0);

  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_DELAY    = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  logic [STAGES-1:0] sync_q;
  logic              rst_sync;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [N_DOM-1:0]  nrst_q, nrst_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;

  logic [N_DOM-1:0]  release_mask;
  logic              ready_cur;

  // The master reset asserts at once but is released only after it has
  // passed through STAGES flops. This avoids a metastable release.
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[STAGES-1];

  // Build a one-hot mask of the domain currently being sequenced. The mask
  // selects both the bit to release and the ready bit to watch.
  always_comb begin
    release_mask = '0;
    for (int i = 0; i < N_DOM; i++) begin
      release_mask[i] = (idx_q == IDX_W'(i));
    end
  end

  assign ready_cur = |(RDY_I & release_mask);
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_W'(1));

  // Next-state and next-output logic. Every output is computed here and
  // then registered. A soft reset overrides every other transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nrst_d  = nrst_q;
    done_d  = done_q;
    fault_d = fault_q;
    fidx_d  = fidx_q;

    if (SRST_I) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      nrst_d  = '0;
      done_d  = 1'b0;
      fault_d = 1'b0;
      fidx_d  = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          nrst_d = '0;
          done_d = 1'b0;
          if (rst_sync) begin
            state_d = ST_DELAY;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end

        ST_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            nrst_d  = nrst_q | release_mask;
            cnt_d   = '0;
            state_d = ST_WAIT_RDY;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_WAIT_RDY: begin
          if (ready_cur) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = '0;
              state_d = ST_DELAY;
            end
          end else begin
            cnt_d = cnt_inc;
            if (TMO_EN && (cnt_q == TMO_LAST)) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
              fidx_d  = idx_q;
              nrst_d  = '0;
            end
          end
        end

        ST_DONE: begin
          nrst_d = '1;
          done_d = 1'b1;
        end

        ST_FAULT: begin
          nrst_d = '0;
          done_d = 1'b0;
        end

        default: begin
          state_d = ST_HOLD;
          idx_d   = '0;
          cnt_d   = '0;
          nrst_d  = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers. A low master reset clears them at once,
  // without a clock edge, so every domain re-enters reset right away.
  always_ff @(posedge CLK_I or negedge NRST_I) begin
    if (!NRST_I) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      nrst_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      fidx_q  <= fidx_d;
    end
  end

  assign NRST_O      = nrst_q;
  assign DONE_O      = done_q;
  assign FAULT_O     = fault_q;
  assign FAULT_IDX_O = fidx_q;

endmodule

// File: tb/tb_nrst_sequencer.sv
// tb_nrst_sequencer: scoreboard bench for the ordered reset sequencer.
// When stimulus is driven, the bench queues the expected outputs for future
// clock edges. A negedge monitor pops each entry on its cycle and compares it.

module tb_nrst_sequencer;

  localparam int N_DOM   = 3;
  localparam int STAGES  = 3;
  localparam int DLY_CYC = 4;
  localparam int TMO_CYC = 8;

  logic             clk = 1'b0;
  logic             nrst_i;
  logic             srst_i;
  logic [N_DOM-1:0] rdy_i;
  logic [N_DOM-1:0] nrst_o;
  logic             done_o;
  logic             fault_o;
  logic [1:0]       fault_idx_o;

  int cycle = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         scen;
    logic [2:0] nrst;
    logic       done;
    logic       fault;
    logic [1:0] fidx;
  } exp_t;

  exp_t score_q[$];

  nrst_sequencer #(
    .N_DOM  (N_DOM),
    .STAGES (STAGES),
    .DLY_CYC(DLY_CYC),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .CLK_I      (clk),
    .NRST_I     (nrst_i),
    .SRST_I     (srst_i),
    .RDY_I      (rdy_i),
    .NRST_O     (nrst_o),
    .DONE_O     (done_o),
    .FAULT_O    (fault_o),
    .FAULT_IDX_O(fault_idx_o)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Count rising edges so expectations can name an absolute cycle.
  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic nrst, input logic srst, input logic [2:0] rdy);
    nrst_i = nrst;
    srst_i = srst;
    rdy_i  = rdy;
  endtask

  task automatic expectAt(input int scen, input int cyc, input logic [2:0] nrst,
                          input logic done, input logic fault, input logic [1:0] fidx);
    exp_t e;
    e.cyc   = cyc;
    e.scen  = scen;
    e.nrst  = nrst;
    e.done  = done;
    e.fault = fault;
    e.fidx  = fidx;
    score_q.push_back(e);
  endtask

  // Compare every queued expectation whose cycle has arrived. An entry whose
  // cycle has already passed is reported as late.
  always @(negedge clk) begin
    for (int i = score_q.size() - 1; i >= 0; i--) begin
      if (score_q[i].cyc < cycle) begin
        checkOutput($sformatf("s%0d_late_c%0d", score_q[i].scen, score_q[i].cyc),
                    32'(cycle), 32'(score_q[i].cyc));
        score_q.delete(i);
      end else if (score_q[i].cyc == cycle) begin
        checkOutput($sformatf("s%0d_c%0d_nrst", score_q[i].scen, score_q[i].cyc),
                    32'(nrst_o), 32'(score_q[i].nrst));
        checkOutput($sformatf("s%0d_c%0d_done", score_q[i].scen, score_q[i].cyc),
                    32'(done_o), 32'(score_q[i].done));
        checkOutput($sformatf("s%0d_c%0d_fault", score_q[i].scen, score_q[i].cyc),
                    32'(fault_o), 32'(score_q[i].fault));
        checkOutput($sformatf("s%0d_c%0d_fidx", score_q[i].scen, score_q[i].cyc),
                    32'(fault_idx_o), 32'(score_q[i].fidx));
        score_q.delete(i);
      end
    end
  end

  int base;
  int s;
  int c;

  // Run the scenarios in order. Each one queues its expectations relative to
  // the edge where its stimulus takes effect.
  initial begin
    applyStimulus(1'b0, 1'b0, 3'b000);
    repeat (3) @(negedge clk);
    checkOutput("reset_nrst", 32'(nrst_o), 32'h0);
    checkOutput("reset_done", 32'(done_o), 32'h0);
    checkOutput("reset_fault", 32'(fault_o), 32'h0);
    checkOutput("reset_fidx", 32'(fault_idx_o), 32'h0);

    // Scenario 1: power-up with every domain ready.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b111);
    base = cycle;
    expectAt(1, base + 7,  3'b000, 1'b0, 1'b0, 2'd0);
    expectAt(1, base + 8,  3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(1, base + 12, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(1, base + 13, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(1, base + 17, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(1, base + 18, 3'b111, 1'b0, 1'b0, 2'd0);
    expectAt(1, base + 19, 3'b111, 1'b1, 1'b0, 2'd0);
    repeat (22) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b000);
    expectAt(1, base + 24, 3'b111, 1'b1, 1'b0, 2'd0);
    repeat (3) @(negedge clk);

    // Scenario 2: async abort from DONE, then a timeout on domain 1.
    #2 applyStimulus(1'b0, 1'b0, 3'b101);
    #1 checkOutput("abort_from_done_nrst", 32'(nrst_o), 32'h0);
    checkOutput("abort_from_done_done", 32'(done_o), 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b101);
    base = cycle;
    expectAt(2, base + 8,  3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(2, base + 12, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(2, base + 13, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(2, base + 20, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(2, base + 21, 3'b000, 1'b0, 1'b1, 2'd1);
    expectAt(2, base + 24, 3'b000, 1'b0, 1'b1, 2'd1);
    repeat (25) @(negedge clk);

    // Scenario 3: a single-cycle soft reset clears the fault and restarts.
    applyStimulus(1'b1, 1'b1, 3'b111);
    s = cycle + 1;
    expectAt(3, s,      3'b000, 1'b0, 1'b0, 2'd0);
    expectAt(3, s + 4,  3'b000, 1'b0, 1'b0, 2'd0);
    expectAt(3, s + 5,  3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(3, s + 9,  3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(3, s + 10, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(3, s + 15, 3'b111, 1'b0, 1'b0, 2'd0);
    expectAt(3, s + 16, 3'b111, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b111);
    repeat (18) @(negedge clk);

    // Scenario 4: soft reset held for ten cycles while in DONE.
    applyStimulus(1'b1, 1'b1, 3'b111);
    c = cycle;
    for (int k = 1; k <= 10; k++) begin
      expectAt(4, c + k, 3'b000, 1'b0, 1'b0, 2'd0);
    end
    expectAt(4, c + 14, 3'b000, 1'b0, 1'b0, 2'd0);
    expectAt(4, c + 15, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(5, c + 16, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(5, c + 17, 3'b001, 1'b0, 1'b0, 2'd0);
    repeat (10) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b111);
    repeat (7) @(negedge clk);

    // Scenario 5: a short, off-edge master reset pulse while DELAY runs for domain 1.
    #2 applyStimulus(1'b0, 1'b0, 3'b000);
    #1 checkOutput("abort_mid_delay_nrst", 32'(nrst_o), 32'h0);
    checkOutput("abort_mid_delay_done", 32'(done_o), 32'h0);
    checkOutput("abort_mid_delay_fault", 32'(fault_o), 32'h0);
    #1 applyStimulus(1'b1, 1'b0, 3'b000);
    base = cycle;
    expectAt(5, base + 1, 3'b000, 1'b0, 1'b0, 2'd0);
    expectAt(5, base + 7, 3'b000, 1'b0, 1'b0, 2'd0);
    expectAt(5, base + 8, 3'b001, 1'b0, 1'b0, 2'd0);

    // Scenario 6: ready for domain 0 arrives on the timeout edge and wins.
    // Domain 1 then never becomes ready and times out.
    expectAt(6, base + 15, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(6, base + 16, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(6, base + 19, 3'b001, 1'b0, 1'b0, 2'd0);
    expectAt(6, base + 20, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(6, base + 27, 3'b011, 1'b0, 1'b0, 2'd0);
    expectAt(6, base + 28, 3'b000, 1'b0, 1'b1, 2'd1);
    repeat (15) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 3'b001);
    repeat (14) @(negedge clk);

    for (int k = 0; k < 50 && score_q.size() > 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(score_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
